// File: rtl/alarm_display_scanner.sv
// Multiplexed 7-segment scanner with frame-synchronous double buffering and anti-ghost dead time.
// Optional digit blinking is compiled in with the SCAN_BLINK_EN macro.
module alarm_display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 100000,
    parameter int DEAD         = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] DEAD_V   = CNT_W'(DEAD);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_DIGITS - 1);

    localparam logic [NUM_DIGITS-1:0]   AN_OFF   = {NUM_DIGITS{1'b1}};
    localparam logic [NUM_DIGITS-1:0]   AN_ONE   = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0]   MASK_Z   = {NUM_DIGITS{1'b0}};
    localparam logic [4*NUM_DIGITS-1:0] DIGITS_Z = {(4*NUM_DIGITS){1'b0}};

    // Active-low hex decode, seg[0]=a .. seg[6]=g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]        cnt_r;
    logic [IDX_W-1:0]        idx_r;
    logic [CNT_W-1:0]        cnt_next_s;
    logic [IDX_W-1:0]        idx_next_s;
    logic                    slot_end_s;
    logic                    boundary_s;
    logic                    take_load_s;
    logic                    promote_s;
    logic                    stash_s;

    logic [4*NUM_DIGITS-1:0] act_digits_r;
    logic [NUM_DIGITS-1:0]   act_blank_r;
    logic [NUM_DIGITS-1:0]   act_dp_r;
    logic                    act_valid_r;
    logic [4*NUM_DIGITS-1:0] pend_digits_r;
    logic [NUM_DIGITS-1:0]   pend_blank_r;
    logic [NUM_DIGITS-1:0]   pend_dp_r;
    logic                    pend_r;

    logic                    blink_dark_s;
    logic                    dark_s;
    logic [3:0]              nib_s;
    logic [NUM_DIGITS-1:0]   an_s;
    logic [6:0]              seg_s;
    logic                    dp_s;

    logic [NUM_DIGITS-1:0]   an_r;
    logic [6:0]              seg_r;
    logic                    dp_r;
    logic                    frame_done_r;

    // Scan position advance and buffer-transfer decisions for this cycle.
    always_comb begin
        slot_end_s = (cnt_r == CNT_MAX);
        boundary_s = slot_end_s && (idx_r == IDX_MAX);
        if (slot_end_s) begin
            cnt_next_s = CNT_ZERO;
            if (idx_r == IDX_MAX) begin
                idx_next_s = IDX_ZERO;
            end else begin
                idx_next_s = idx_r + IDX_ONE;
            end
        end else begin
            cnt_next_s = cnt_r + CNT_ONE;
            idx_next_s = idx_r;
        end
        take_load_s = load && boundary_s;
        promote_s   = boundary_s && pend_r && !load;
        stash_s     = load && !boundary_s;
    end

    // Prescaler, digit index and frame_done; frame_done is predicted one cycle early so it is high in the boundary cycle itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r        <= CNT_ZERO;
            idx_r        <= IDX_ZERO;
            frame_done_r <= 1'b0;
        end else begin
            cnt_r        <= cnt_next_s;
            idx_r        <= idx_next_s;
            frame_done_r <= (cnt_next_s == CNT_MAX) && (idx_next_s == IDX_MAX);
        end
    end

    // Pending/active double buffer; active only changes on a frame boundary so a frame never mixes old and new data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_digits_r  <= DIGITS_Z;
            act_blank_r   <= MASK_Z;
            act_dp_r      <= MASK_Z;
            act_valid_r   <= 1'b0;
            pend_digits_r <= DIGITS_Z;
            pend_blank_r  <= MASK_Z;
            pend_dp_r     <= MASK_Z;
            pend_r        <= 1'b0;
        end else if (take_load_s) begin
            act_digits_r <= digits;
            act_blank_r  <= blank_mask;
            act_dp_r     <= dp_mask;
            act_valid_r  <= 1'b1;
            pend_r       <= 1'b0;
        end else if (promote_s) begin
            act_digits_r <= pend_digits_r;
            act_blank_r  <= pend_blank_r;
            act_dp_r     <= pend_dp_r;
            act_valid_r  <= 1'b1;
            pend_r       <= 1'b0;
        end else if (stash_s) begin
            pend_digits_r <= digits;
            pend_blank_r  <= blank_mask;
            pend_dp_r     <= dp_mask;
            pend_r        <= 1'b1;
        end else begin
            pend_r <= pend_r;
        end
    end

`ifdef SCAN_BLINK_EN
    localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_ZERO = FCNT_W'(0);
    localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);
    localparam logic [FCNT_W-1:0] FCNT_MAX  = FCNT_W'(BLINK_FRAMES - 1);

    logic [NUM_DIGITS-1:0] act_blink_r;
    logic [NUM_DIGITS-1:0] pend_blink_r;
    logic [FCNT_W-1:0]     fcnt_r;
    logic                  phase_r;

    // Blink mask follows the same pending/active transfer as the other masks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_blink_r  <= MASK_Z;
            pend_blink_r <= MASK_Z;
        end else if (take_load_s) begin
            act_blink_r <= blink_mask;
        end else if (promote_s) begin
            act_blink_r <= pend_blink_r;
        end else if (stash_s) begin
            pend_blink_r <= blink_mask;
        end else begin
            act_blink_r <= act_blink_r;
        end
    end

    // Frame counter toggles the blink phase every BLINK_FRAMES boundaries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fcnt_r  <= FCNT_ZERO;
            phase_r <= 1'b0;
        end else if (boundary_s) begin
            if (fcnt_r == FCNT_MAX) begin
                fcnt_r  <= FCNT_ZERO;
                phase_r <= ~phase_r;
            end else begin
                fcnt_r <= fcnt_r + FCNT_ONE;
            end
        end else begin
            fcnt_r <= fcnt_r;
        end
    end

    assign blink_dark_s = phase_r & act_blink_r[idx_r];
`else
    logic unused_blink_s;
    assign unused_blink_s = ^blink_mask;
    assign blink_dark_s   = 1'b0;
`endif

    // Drive pattern for the current slot; nothing is shown until data has reached the active buffer.
    always_comb begin
        nib_s  = act_digits_r[{idx_r, 2'b00} +: 4];
        dark_s = !act_valid_r || act_blank_r[idx_r] || blink_dark_s;
        if (dark_s) begin
            an_s  = AN_OFF;
            seg_s = 7'h7F;
            dp_s  = 1'b1;
        end else begin
            seg_s = hex_to_seg(nib_s);
            dp_s  = ~act_dp_r[idx_r];
            if (cnt_r < DEAD_V) begin
                an_s = AN_OFF;
            end else begin
                an_s = ~(AN_ONE << idx_r);
            end
        end
    end

    // Output registers: one cycle behind the scan state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_r  <= AN_OFF;
            seg_r <= 7'h7F;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= an_s;
            seg_r <= seg_s;
            dp_r  <= dp_s;
        end
    end

    assign an         = an_r;
    assign seg        = seg_r;
    assign dp         = dp_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_alarm_display_scanner.sv
// Self-checking bench for alarm_display_scanner: directed table, hand sequences and random stimulus vs. a time-based model.
module tb_alarm_display_scanner;

    localparam int N  = 4;
    localparam int P  = 8;
    localparam int D  = 2;
    localparam int BF = 2;
    localparam int FR = N * P;
`ifdef SCAN_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  blank_mask, dp_mask, blink_mask;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, frame_done;

    int vectors = 0;
    int miscompares = 0;

    alarm_display_scanner #(.NUM_DIGITS(N), .PRESCALE(P), .DEAD(D), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .digits(digits), .blank_mask(blank_mask),
        .dp_mask(dp_mask), .blink_mask(blink_mask), .load(load),
        .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Model: position is derived from the cycle count t since reset release.
    int          t, frames;
    logic [15:0] m_dig, p_dig;
    logic [3:0]  m_bl, m_dp, m_bk, p_bl, p_dp, p_bk;
    bit          m_valid, m_pend;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd;
    logic [6:0]  hex_tab [16];

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  bl;
        logic [3:0]  dpm;
        int          slot;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;
    vec_t tbl [12];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
        end
    endfunction

    function automatic void model_reset();
        t = 0; frames = 0;
        m_dig = 16'h0; p_dig = 16'h0;
        m_bl = 4'h0; m_dp = 4'h0; m_bk = 4'h0;
        p_bl = 4'h0; p_dp = 4'h0; p_bk = 4'h0;
        m_valid = 1'b0; m_pend = 1'b0;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    endfunction

    function automatic void model_edge();
        int  cnt, idx;
        bit  phase, dark;
        cnt   = t % P;
        idx   = (t / P) % N;
        phase = BLINK_ON && (((frames / BF) % 2) == 1);
        dark  = !m_valid || m_bl[idx] || (phase && m_bk[idx]);
        if (dark) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            e_seg = hex_tab[m_dig[idx*4 +: 4]];
            e_dp  = !m_dp[idx];
            e_an  = (cnt < D) ? 4'hF : ~(4'b0001 << idx);
        end
        if ((t % FR) == FR - 1) begin
            frames++;
            if (load) begin
                m_dig = digits; m_bl = blank_mask; m_dp = dp_mask; m_bk = blink_mask;
                m_valid = 1'b1; m_pend = 1'b0;
            end else if (m_pend) begin
                m_dig = p_dig; m_bl = p_bl; m_dp = p_dp; m_bk = p_bk;
                m_valid = 1'b1; m_pend = 1'b0;
            end
        end else if (load) begin
            p_dig = digits; p_bl = blank_mask; p_dp = dp_mask; p_bk = blink_mask;
            m_pend = 1'b1;
        end
        t++;
        e_fd = ((t % FR) == FR - 1);
    endfunction

    task automatic cycle(input bit ld, input logic [15:0] d, input logic [3:0] bm, input logic [3:0] dm, input logic [3:0] km);
        load = ld; digits = d; blank_mask = bm; dp_mask = dm; blink_mask = km;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("an", an, e_an);
        check("seg", seg, e_seg);
        check("dp", dp, e_dp);
        check("frame_done", frame_done, e_fd);
        load = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, digits, blank_mask, dp_mask, blink_mask);
    endtask

    task automatic apply_reset();
        reset = 1'b0; load = 1'b0; digits = 16'h0;
        blank_mask = 4'h0; dp_mask = 4'h0; blink_mask = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_fd", frame_done, 1'b0);
        model_reset();
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        miscompares++;
        $display("FAIL timeout: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int ones, lit_err;
        bit lit;
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        tbl[0]  = '{16'h3A71, 4'h0,    4'h0,    0, 4'b1110, 7'h79, 1'b1};
        tbl[1]  = '{16'h3A71, 4'h0,    4'h0,    1, 4'b1101, 7'h78, 1'b1};
        tbl[2]  = '{16'h3A71, 4'h0,    4'h0,    2, 4'b1011, 7'h08, 1'b1};
        tbl[3]  = '{16'h3A71, 4'h0,    4'h0,    3, 4'b0111, 7'h30, 1'b1};
        tbl[4]  = '{16'h4444, 4'b0100, 4'b0001, 2, 4'b1111, 7'h7F, 1'b1};
        tbl[5]  = '{16'h4444, 4'b0100, 4'b0001, 0, 4'b1110, 7'h19, 1'b0};
        tbl[6]  = '{16'h8BC0, 4'h0,    4'b1010, 1, 4'b1101, 7'h46, 1'b0};
        tbl[7]  = '{16'h8BC0, 4'h0,    4'b1010, 2, 4'b1011, 7'h03, 1'b1};
        tbl[8]  = '{16'hDEF5, 4'h0,    4'h0,    3, 4'b0111, 7'h21, 1'b1};
        tbl[9]  = '{16'hDEF5, 4'b1000, 4'h0,    0, 4'b1110, 7'h12, 1'b1};
        tbl[10] = '{16'h8BC0, 4'h0,    4'h0,    3, 4'b0111, 7'h00, 1'b1};
        tbl[11] = '{16'h8BC0, 4'h0,    4'h0,    0, 4'b1110, 7'h40, 1'b1};

        model_reset();
        apply_reset();

        // Directed table: load, let it reach the active buffer, then probe one slot.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, tbl[i].dig, tbl[i].bl, tbl[i].dpm, 4'h0);
            while ((t % FR) != 0) idle();
            while ((t % FR) != tbl[i].slot * P + 1) idle();
            check("tbl_dead_an", an, 4'hF);
            while ((t % FR) != tbl[i].slot * P + D + 3) idle();
            check("tbl_an", an, tbl[i].an);
            check("tbl_seg", seg, tbl[i].seg);
            check("tbl_dp", dp, tbl[i].dp);
        end

        // Two loads in one frame: only the second ever appears.
        while ((t % FR) != 5) idle();
        cycle(1'b1, 16'h1111, 4'h0, 4'h0, 4'h0);
        repeat (3) idle();
        cycle(1'b1, 16'h2222, 4'h0, 4'h0, 4'h0);
        while ((t % FR) != 0) idle();
        ones = 0;
        for (int k = 0; k < FR; k++) begin
            idle();
            if (seg === 7'h79) ones++;
            if ((t % FR) == 2 * P + 5) check("double_load_seg", seg, 7'h24);
        end
        check("double_load_no_old", ones, 0);

        // Load in the frame_done cycle goes straight to the active buffer.
        while ((t % FR) != FR - 1) idle();
        check("fd_cycle", frame_done, 1'b1);
        cycle(1'b1, 16'h4444, 4'h0, 4'h0, 4'h0);
        idle();
        check("bnd_load_seg0", seg, 7'h19);
        check("bnd_load_dead", an, 4'hF);
        while ((t % FR) != D + 3) idle();
        check("bnd_load_an", an, 4'b1110);
        check("bnd_load_seg", seg, 7'h19);

        // Asynchronous reset in slot 2 clears outputs without a clock edge and drops data.
        while ((t % FR) != 2 * P + 5) idle();
        check("pre_rst_an", an, 4'b1011);
        #2;
        reset = 1'b0;
        #1;
        check("async_an", an, 4'hF);
        check("async_seg", seg, 7'h7F);
        check("async_dp", dp, 1'b1);
        check("async_fd", frame_done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset = 1'b1;
        load = 1'b0;
        lit_err = 0;
        for (int k = 0; k < FR + 8; k++) begin
            idle();
            if (an !== 4'hF || seg !== 7'h7F) lit_err++;
        end
        check("post_rst_blank", lit_err, 0);

        // Blink behaviour on digit 0.
        model_reset();
        apply_reset();
        cycle(1'b1, 16'h0000, 4'h0, 4'h0, 4'b0001);
        for (int f = 1; f <= 4; f++) begin
            while (t != FR * f + 5) idle();
            lit = !BLINK_ON || (((f / BF) % 2) == 0);
            check("blink_an", an, lit ? 4'b1110 : 4'b1111);
            check("blink_seg", seg, lit ? 7'h40 : 7'h7F);
        end

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom % 16) == 0, 16'($urandom),
                  (($urandom % 4) == 0) ? 4'($urandom) : 4'h0,
                  4'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alarm_display_scanner.md
ALARM_DISPLAY_SCANNER -- requirements
Module: alarm_display_scanner

Interface
REQ-001 The block SHALL have the parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 The block SHALL have the parameter PRESCALE, default 100000: clk cycles per digit slot, legal when PRESCALE >= DEAD+2.
REQ-003 The block SHALL have the parameter DEAD, default 16: anti-ghost cycles at the start of each slot during which all anodes are off.
REQ-004 The block SHALL have the parameter BLINK_FRAMES, default 64: frames per blink half-period.
REQ-005 The block SHALL have the port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-006 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have the port digits, input, 4*NUM_DIGITS bits: hex nibble per digit; digit i is bits [4i+3:4i].
REQ-008 The block SHALL have the port blank_mask, input, NUM_DIGITS bits: 1 = digit dark.
REQ-009 The block SHALL have the port dp_mask, input, NUM_DIGITS bits: 1 = decimal point lit.
REQ-010 The block SHALL have the port blink_mask, input, NUM_DIGITS bits: 1 = digit blinks.
REQ-011 The block SHALL have the port load, input, 1 bit: a one-cycle strobe that captures digits and all three masks.
REQ-012 The block SHALL have the port an, output, NUM_DIGITS bits: anodes, active-low, at most one low.
REQ-013 The block SHALL have the port seg, output, 7 bits: segments, active-low; seg[0]=a .. seg[6]=g.
REQ-014 The block SHALL have the port dp, output, 1 bit: decimal point, active-low.
REQ-015 The block SHALL have the port frame_done, output, 1 bit: a one-cycle pulse when the last digit slot ends.

Function
REQ-016 The prescaler cnt SHALL count 0..PRESCALE-1 and wrap; a slot ends in the cycle where cnt==PRESCALE-1.
REQ-017 The digit index idx SHALL increment at each slot end and wrap from NUM_DIGITS-1 to 0.
REQ-018 Frame boundary: a slot end with idx==NUM_DIGITS-1; frame_done SHALL be 1 in exactly that cycle.
REQ-019 A load SHALL copy its inputs into a pending buffer and set pend; while pend is 1, a later load overwrites the buffer.
REQ-020 At a frame boundary with pend=1, the pending buffer SHALL move to the active buffer and pend SHALL clear.
REQ-021 If load coincides with a frame boundary, the load's inputs SHALL go directly to the active buffer and pend SHALL clear.
REQ-022 The display SHALL never show a mix of old and new data within one frame.
REQ-023 an, seg and dp SHALL be registered, reflecting the cnt/idx/active state of the previous cycle (1-cycle latency).
REQ-024 When cnt < DEAD, an SHALL be all 1 (off); otherwise an[idx]=0 and all other bits SHALL be 1.
REQ-025 seg SHALL be the hex decode of active digit idx, covering 0-9 and A,b,C,d,E,F; for example 0 -> 7'b1000000 and 8 -> 7'b0000000.
REQ-026 dp SHALL be ~dp_mask[idx].
REQ-027 A blanked digit, or a blinked-off digit, SHALL produce seg=7'h7F, dp=1, and an all 1 for its whole slot.

Reset
REQ-028 While reset=0, the block SHALL immediately force an all 1, seg=7'h7F, dp=1, frame_done=0, cnt=0, idx=0, active and pending buffers 0, pend=0, blink phase 0.
REQ-029 After reset deasserts, the first slot SHALL start at cnt=0, idx=0.
REQ-030 Reset asserted mid-frame SHALL discard all pending and active data.

Configuration
REQ-031 With macro SCAN_BLINK_EN defined, a frame counter SHALL toggle the blink phase every BLINK_FRAMES frame boundaries.
REQ-032 With SCAN_BLINK_EN defined, a digit whose active blink_mask bit is 1 SHALL be dark while the phase is 1.
REQ-033 Without SCAN_BLINK_EN, the blink_mask port SHALL remain present but be ignored, and no frame counter SHALL be built.

Verification (NUM_DIGITS=4, PRESCALE=8, DEAD=2, BLINK_FRAMES=2)
REQ-034 Reset release, load digits=16'h3A71, masks 0, then wait one full frame -> load applies at the next boundary, after which slots show 1,7,A,3 on an=1110,1101,1011,0111, an=1111 for the first 2 cycles of each slot, and frame_done every 32 cycles.
REQ-035 load 16'h1111 then 16'h2222 within the same frame -> the next frame shows only 2 on all digits, with no 1 appearing.
REQ-036 load asserted exactly in the frame_done cycle with 16'h4444 -> 4 is displayed from the following slot 0.
REQ-037 blank_mask=4'b0100, dp_mask=4'b0001 -> digit 2 is dark with an=1111 in its slot, and digit 0 shows dp=0.
REQ-038 SCAN_BLINK_EN defined, blink_mask=4'b0001 -> digit 0 is lit for 2 frames and dark for 2 frames, repeating; with the macro undefined it is always lit.
REQ-039 reset pulsed low mid-slot 2 -> outputs go to reset values without waiting for a clock edge, and the buffered data is lost (display blank until the next load).
